// File: rtl/data_mem_responder.sv
// Data-memory responder: serves RV32I loads/stores on a word RAM with a fixed access latency.
// Misaligned, out-of-range and illegal-funct3 requests get an error response and never touch the RAM.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | legal access counting down its latency
// RESP   | response held until the CPU takes it
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_ERR
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic        sel_we;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr, sel_wdata;
  logic        accept, access;
  logic        f3_bad, misal, oor, sel_err;
  logic [ADDR_WIDTH-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wword, rword, shifted, load_val;

  // At the accept edge the live request is used; afterwards the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_we    = REQ_WE;
      sel_f3    = REQ_FUNCT3;
      sel_addr  = REQ_ADDR;
      sel_wdata = REQ_WDATA;
    end else begin
      sel_we    = we_q;
      sel_f3    = funct3_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
    end
  end

  always_comb begin
    f3_bad = sel_we ? (sel_f3 > 3'd2) : ((sel_f3 == 3'd3) || (sel_f3 > 3'd5));
    case (sel_f3[1:0])
      2'd1:    misal = sel_addr[0];
      2'd2:    misal = |sel_addr[1:0];
      default: misal = 1'b0;
    endcase
    oor     = |(sel_addr >> (ADDR_WIDTH + 2));
    sel_err = f3_bad | misal | oor;
  end

  assign widx = sel_addr[ADDR_WIDTH+1:2];

  always_comb begin
    be    = 4'b1111;
    wword = sel_wdata;
    case (sel_f3[1:0])
      2'd0: begin
        be    = 4'b0001 << sel_addr[1:0];
        wword = {4{sel_wdata[7:0]}};
      end
      2'd1: begin
        be    = sel_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{sel_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = sel_wdata;
      end
    endcase
  end

  assign rword   = mem[widx];
  assign shifted = rword >> {sel_addr[1:0], 3'b000};

  always_comb begin
    case (sel_f3)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_val = {24'h0, shifted[7:0]};
      3'd5:    load_val = {16'h0, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          accept = 1'b1;
          if (sel_err || (LATENCY == 0)) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (RESP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept && !RST) begin
      we_q     <= REQ_WE;
      funct3_q <= REQ_FUNCT3;
      addr_q   <= REQ_ADDR;
      wdata_q  <= REQ_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q   <= sel_err;
      rdata_q <= (sel_err || sel_we) ? 32'h0 : load_val;
    end
  end

  // Reset has priority, so a store leaving WAIT on a reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (access && !RST && !sel_err && sel_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign REQ_READY  = (state_q == S_IDLE);
  assign RESP_VALID = (state_q == S_RESP);
  assign RESP_RDATA = rdata_q;
  assign RESP_ERR   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=0 instances checked against a byte-array model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, resp_ready;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        sel;

  logic        rr_a, rv_a, err_a, rr_b, rv_b, err_b;
  logic [31:0] rd_a, rd_b;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mm [2][4096];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_l2 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid & ~sel), .REQ_READY(rr_a),
    .REQ_WE(req_we), .REQ_FUNCT3(req_f3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RESP_VALID(rv_a), .RESP_READY(resp_ready & ~sel), .RESP_RDATA(rd_a), .RESP_ERR(err_a)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_l0 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid & sel), .REQ_READY(rr_b),
    .REQ_WE(req_we), .REQ_FUNCT3(req_f3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RESP_VALID(rv_b), .RESP_READY(resp_ready & sel), .RESP_RDATA(rd_b), .RESP_ERR(err_b)
  );

  assign req_ready  = sel ? rr_b  : rr_a;
  assign resp_valid = sel ? rv_b  : rv_a;
  assign resp_rdata = sel ? rd_b  : rd_a;
  assign resp_err   = sel ? err_b : err_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit illegal;
    int size;
    illegal = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 >= 3'd6));
    size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    return illegal || ((a % size) != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] exp_load(input int w, input logic [2:0] f3, input logic [31:0] a);
    int ai;
    logic [15:0] h;
    ai = int'(a);
    case (f3)
      3'd0: return {{24{mm[w][ai][7]}}, mm[w][ai]};
      3'd4: return {24'h0, mm[w][ai]};
      3'd1: begin h = {mm[w][ai+1], mm[w][ai]}; return {{16{h[15]}}, h}; end
      3'd5: begin h = {mm[w][ai+1], mm[w][ai]}; return {16'h0, h}; end
      default: return {mm[w][ai+3], mm[w][ai+2], mm[w][ai+1], mm[w][ai]};
    endcase
  endfunction

  task automatic model_store(input int w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int size;
    logic [31:0] tmp;
    size = (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
    for (int i = 0; i < size; i++) begin
      tmp = wd >> (8 * i);
      mm[w][int'(a) + i] = tmp[7:0];
    end
  endtask

  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout_ready", 32'(req_ready), 32'd1);
    req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 40) begin
      chk("ready_low_while_busy", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("valid_after_ack", 32'(resp_valid), 32'd0);
    chk("ready_after_ack", 32'(req_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] got);
    int n, w, lat;
    bit e;
    logic [31:0] er;
    w   = sel ? 1 : 0;
    lat = sel ? 0 : 2;
    e   = exp_err(we, f3, a);
    er  = (e || we) ? 32'h0 : exp_load(w, f3, a);
    send(we, f3, a, wd);
    wait_resp(n);
    chk({tag, "_latency"}, 32'(n), e ? 32'd0 : 32'(lat));
    chk({tag, "_err"}, 32'(resp_err), 32'(e));
    chk({tag, "_rdata"}, resp_rdata, er);
    got = resp_rdata;
    ack();
    if (!e && we) model_store(w, f3, a, wd);
  endtask

  initial begin
    logic [31:0] got, hold;
    int n;
    bit rwe;
    logic [2:0] rf3;
    logic [31:0] ra;

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 4096; i++) mm[w][i] = 8'h00;

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_valid", 32'(resp_valid), 32'd0);
      chk("reset_rdata", resp_rdata, 32'h0);
      chk("reset_err", 32'(resp_err), 32'd0);
    end

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 32; i++) do_op("fill", 1'b1, 3'd2, 32'(i * 4), 32'h0, got);
    end
    sel = 1'b0;

    do_op("sw_word", 1'b1, 3'd2, 32'h40, 32'hDEADBEEF, got);
    do_op("lw_word", 1'b0, 3'd2, 32'h40, 32'h0, got);
    chk("tp_lw_word", got, 32'hDEADBEEF);
    do_op("sb", 1'b1, 3'd0, 32'h41, 32'h00000080, got);
    do_op("lb", 1'b0, 3'd0, 32'h41, 32'h0, got);
    chk("tp_lb", got, 32'hFFFFFF80);
    do_op("lbu", 1'b0, 3'd4, 32'h41, 32'h0, got);
    chk("tp_lbu", got, 32'h00000080);
    do_op("lw_after_sb", 1'b0, 3'd2, 32'h40, 32'h0, got);
    chk("tp_lw_after_sb", got, 32'hDEAD80EF);
    do_op("sh", 1'b1, 3'd1, 32'h42, 32'h00008001, got);
    do_op("lhu", 1'b0, 3'd5, 32'h42, 32'h0, got);
    chk("tp_lhu", got, 32'h00008001);
    do_op("lh", 1'b0, 3'd1, 32'h42, 32'h0, got);
    chk("tp_lh", got, 32'hFFFF8001);

    do_op("lh_misal", 1'b0, 3'd1, 32'h43, 32'h0, got);
    do_op("sw_misal", 1'b1, 3'd2, 32'h42, 32'h12345678, got);
    do_op("lw_unchanged", 1'b0, 3'd2, 32'h40, 32'h0, got);
    chk("tp_lw_unchanged", got, 32'h800180EF);
    do_op("ld_f3_3", 1'b0, 3'd3, 32'h40, 32'h0, got);
    do_op("lw_oor", 1'b0, 3'd2, 32'h1000, 32'h0, got);

    // Backpressure: response held, a second request waiting the whole time.
    send(1'b0, 3'd2, 32'h40, 32'h0);
    wait_resp(n);
    chk("bp_latency", 32'(n), 32'd2);
    hold = exp_load(0, 3'd2, 32'h40);
    req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h44; req_wdata = 32'h0BADCAFE; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, hold);
      chk("bp_err", 32'(resp_err), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("bp_valid_after_ack", 32'(resp_valid), 32'd0);
    chk("bp_ready_after_ack", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("bp_second_accepted", 32'(req_ready), 32'd0);
    wait_resp(n);
    chk("bp_second_latency", 32'(n), 32'd2);
    chk("bp_second_err", 32'(resp_err), 32'd0);
    ack();
    model_store(0, 3'd2, 32'h44, 32'h0BADCAFE);
    do_op("lw_bp_store", 1'b0, 3'd2, 32'h44, 32'h0, got);
    chk("tp_lw_bp_store", got, 32'h0BADCAFE);

    // Reset while a store sits in WAIT.
    do_op("sw_zero_50", 1'b1, 3'd2, 32'h50, 32'h0, got);
    do_op("lw_before_rst", 1'b0, 3'd2, 32'h40, 32'h0, got);
    send(1'b1, 3'd2, 32'h50, 32'h11223344);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'h0);
    chk("rst_mid_err", 32'(resp_err), 32'd0);
    do_op("lw_after_rst", 1'b0, 3'd2, 32'h50, 32'h0, got);
    chk("tp_lw_after_rst", got, 32'h0);

    sel = 1'b1;
    do_op("l0_sw", 1'b1, 3'd2, 32'h0, 32'hCAFEF00D, got);
    do_op("l0_lw", 1'b0, 3'd2, 32'h0, 32'h0, got);
    chk("tp_l0_lw", got, 32'hCAFEF00D);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 60; i++) begin
        rwe = 1'($urandom_range(0, 1));
        rf3 = 3'($urandom_range(0, 7));
        ra  = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 7) == 0) ra = 32'h1000 + $urandom_range(0, 65535);
        do_op("rand", rwe, rf3, ra, $urandom, got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Load/store memory responder: the slave end of the CPU's data-memory request/response interface. It serves RV32I byte, halfword and word loads and stores on a word-organised RAM with a programmable access latency. The CPU's execute stage issues one request at a time and waits for the response before its write-back stage. The block detects misaligned, out-of-range and illegal-funct3 accesses and answers them with an error response instead of touching memory.

## Interface
- ADDR_WIDTH, default 10: RAM word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- LATENCY, default 2: cycles spent in WAIT for legal accesses; legal range 0..15.

- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  responder can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, taken from the low byte/half/word.
- RESP_VALID  out  1  response present.
- RESP_READY  in  1  CPU accepts the response.
- RESP_RDATA  out  32  load result, extended to 32 bits; 0 for stores and errors.
- RESP_ERR  out  1  access rejected.

## Operation
- States: IDLE, WAIT, RESP.
  - REQ_READY = 1 only in IDLE.
  - RESP_VALID = 1 only in RESP.
- Request handshake: REQ_VALID & REQ_READY at a posedge. The responder latches WE, FUNCT3, ADDR and WDATA at that edge.
- The latched request is an error if any of the following holds:
  - Illegal funct3: a load with funct3 3, 6 or 7, or a store with funct3 ≥ 3.
  - Misaligned: halfword with ADDR[0] = 1, or word with ADDR[1:0] ≠ 0.
  - Out of range: ADDR[31:ADDR_WIDTH+2] ≠ 0.
- Error path:
  - IDLE → RESP directly with RESP_ERR = 1 and RESP_RDATA = 0.
  - Memory is never written.
- Legal path, LATENCY > 0: IDLE → WAIT. A down-counter is loaded with LATENCY−1. WAIT → RESP on the edge where the counter is 0.
- Legal path, LATENCY = 0: IDLE → RESP directly.
- The access is performed on the edge that enters RESP.
  - Store: write only the addressed byte lanes. SB writes lane ADDR[1:0]. SH writes lanes ADDR[1]*2 and +1.
  - Load: read the word and select the lane.
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
    - LW returns the full word.
  - RESP_RDATA and RESP_ERR are registered at that same edge.
- RESP → IDLE on the edge where RESP_READY = 1. RESP_RDATA and RESP_ERR hold their values until the next response is registered.
- REQ_VALID is ignored while not in IDLE; no queueing, one request outstanding.
- Read-after-write: a load following a store to the same word returns the stored data.
- RAM contents are not cleared by reset. Simulation initial contents are all zero.
- Reset (RST = 1 at an edge), from any state:
  - State returns to IDLE, counter = 0.
  - REQ_READY = 1, RESP_VALID = 0, RESP_RDATA = 0, RESP_ERR = 0.
  - A store still in WAIT is discarded (never written).
  - A store already in RESP stays committed.
  - RST has priority over every handshake on the same edge.

## Timing
- Let E0 be the request-accept edge.
  - Legal access: RESP_VALID is high in the cycle after edge E0+LATENCY.
  - Error: RESP_VALID is high in the cycle after E0, regardless of LATENCY.
- Response accept edge E1: RESP_VALID is low after E1 and REQ_READY is high after E1.
- A new request can be accepted at edge E1+1 at the earliest.
- Best-case throughput is one request per LATENCY+2 cycles.
- REQ_READY and RESP_VALID are decoded from the registered state only. They never depend combinationally on REQ_VALID or RESP_READY.
- Counter width is 4 bits; no wrap occurs for legal LATENCY values.

## Test plan
- Word round trip, LATENCY=2: SW 0xDEADBEEF @0x40, then LW @0x40 → RDATA 0xDEADBEEF, ERR 0. RESP_VALID appears 2 edges after each accept edge, and REQ_READY is low in between.
- Byte and half lanes, continuing from the first scenario:
  - SB 0x80 @0x41, then LB @0x41 → 0xFFFFFF80; LBU @0x41 → 0x00000080; LW @0x40 → 0xDEAD80EF.
  - SH 0x8001 @0x42, then LHU @0x42 → 0x00008001; LH @0x42 → 0xFFFF8001.
- Errors:
  - LH @0x43 → ERR 1, RDATA 0, RESP_VALID the cycle after accept.
  - SW 0x12345678 @0x42 → ERR 1; a following LW @0x40 is unchanged.
  - Load with funct3 3 → ERR 1.
  - LW @0x1000 with ADDR_WIDTH=10 → ERR 1.
- Backpressure: hold RESP_READY low 5 cycles with REQ_VALID high throughout.
  - RESP_VALID, RDATA and ERR stay stable and REQ_READY stays 0.
  - The extra request is accepted only after the response handshake.
- Reset mid-op: with 0x50 containing 0, issue SW 0x11223344 @0x50 and assert RST during WAIT.
  - The cycle after the RST edge shows REQ_READY 1, RESP_VALID 0, RDATA 0, ERR 0.
  - A later LW @0x50 → 0x00000000.
- LATENCY=0 build: LW after SW @0x0 of 0xCAFEF00D → RESP_VALID the cycle after each accept edge, RDATA 0xCAFEF00D.
